multiply_arbiter: RTL and testbench

Two-port arbiter and sequencer for the shared 8-bit shift-add multiplier datapath. It accepts multiply requests from two requesters and grants them round-robin. It latches the winner's operands and drives the datapath control strobes (select, loadA, loadB, shift) through the init/load/shift sequence. It then returns the 2*WIDTH-bit product to the winning requester with a one-cycle done pulse.

---
 rtl/multiply_pkg.sv | 37 +++
 rtl/rr_arbiter2.sv | 13 +
 rtl/multiply_arbiter.sv | 135 +++++++++++++
 tb/tb_multiply_arbiter.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/multiply_pkg.sv
// Shared definitions for the shift-add multiplier controller and its arbiter front end.
package multiply_pkg;

    localparam int unsigned MUL_WIDTH = 8;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_INIT_A = 3'd1;
    localparam logic [2:0] ST_INIT_B = 3'd2;
    localparam logic [2:0] ST_LOAD   = 3'd3;
    localparam logic [2:0] ST_SHIFT  = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

    typedef struct packed {
        logic select;
        logic load_a;
        logic load_b;
        logic shift;
    } dp_ctrl_t;

    // INIT_B clears the product with B (select=0); LOAD conditionally adds A (select=1).
    function automatic dp_ctrl_t strobes_for(input logic [2:0] st);
        dp_ctrl_t c;
        c = '0;
        case (st)
            ST_INIT_A: c.load_a = 1'b1;
            ST_INIT_B: c.load_b = 1'b1;
            ST_LOAD: begin
                c.select = 1'b1;
                c.load_b = 1'b1;
            end
            ST_SHIFT:  c.shift  = 1'b1;
            default:   c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin pick; a tie goes to the requester not granted last.
module rr_arbiter2 (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_idx
);

    assign grant_valid = req0 | req1;
    assign grant_idx   = (req0 & req1) ? ~last_grant : req1;

endmodule

// File: rtl/multiply_arbiter.sv
// Two-requester arbiter and sequencer for the shared shift-add multiplier datapath.
module multiply_arbiter
    import multiply_pkg::*;
#(
    parameter int unsigned WIDTH = MUL_WIDTH
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 req0,
    input  logic                 req1,
    input  logic [WIDTH-1:0]     a0,
    input  logic [WIDTH-1:0]     b0,
    input  logic [WIDTH-1:0]     a1,
    input  logic [WIDTH-1:0]     b1,
    output logic                 ack0,
    output logic                 ack1,
    output logic                 done0,
    output logic                 done1,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy,
    output logic [WIDTH-1:0]     dp_operand_a,
    output logic [WIDTH-1:0]     dp_operand_b,
    output logic                 dp_select,
    output logic                 dp_loadA,
    output logic                 dp_loadB,
    output logic                 dp_shift,
    input  logic [2*WIDTH-1:0]   dp_product
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    logic [2:0]         state_q, state_d;
    logic [CW-1:0]      count_q, count_d;
    logic               last_q, last_d;
    logic               owner_q, owner_d;
    logic [WIDTH-1:0]   opa_q, opa_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [2*WIDTH-1:0] product_q, product_d;
    logic               done0_q, done0_d;
    logic               done1_q, done1_d;

    logic     grant_valid;
    logic     grant_idx;
    dp_ctrl_t ctrl;

    rr_arbiter2 u_arb (
        .req0        (req0),
        .req1        (req1),
        .last_grant  (last_q),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        last_d    = last_q;
        owner_d   = owner_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        product_d = product_q;
        done0_d   = 1'b0;
        done1_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    owner_d = grant_idx;
                    last_d  = grant_idx;
                    opa_d   = grant_idx ? a1 : a0;
                    opb_d   = grant_idx ? b1 : b0;
                    count_d = '0;
                    state_d = ST_INIT_A;
                end
            end
            ST_INIT_A: state_d = ST_INIT_B;
            ST_INIT_B: state_d = ST_LOAD;
            ST_LOAD:   state_d = ST_SHIFT;
            ST_SHIFT: begin
                if (count_q == LAST_ITER) begin
                    state_d = ST_DONE;
                end else begin
                    count_d = count_q + 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_DONE: begin
                product_d = dp_product;
                done0_d   = ~owner_q;
                done1_d   = owner_q;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            last_q    <= 1'b1;
            owner_q   <= 1'b0;
            opa_q     <= '0;
            opb_q     <= '0;
            product_q <= '0;
            done0_q   <= 1'b0;
            done1_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            last_q    <= last_d;
            owner_q   <= owner_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            product_q <= product_d;
            done0_q   <= done0_d;
            done1_q   <= done1_d;
        end
    end

    assign ctrl         = strobes_for(state_q);
    assign dp_select    = ctrl.select;
    assign dp_loadA     = ctrl.load_a;
    assign dp_loadB     = ctrl.load_b;
    assign dp_shift     = ctrl.shift;
    assign dp_operand_a = opa_q;
    assign dp_operand_b = opb_q;
    assign ack0         = (state_q == ST_INIT_A) & ~owner_q;
    assign ack1         = (state_q == ST_INIT_A) & owner_q;
    assign busy         = (state_q != ST_IDLE);
    assign done0        = done0_q;
    assign done1        = done1_q;
    assign product      = product_q;

endmodule

// File: tb/tb_multiply_arbiter.sv
// Scoreboard bench: a cycle-level timing/arbitration model predicts grants, pulses and products.
module tb_multiply_arbiter;

    localparam int W = 8;

    logic           clock = 1'b0;
    logic           reset;
    logic           req0, req1;
    logic [W-1:0]   a0, b0, a1, b1;
    logic           ack0, ack1, done0, done1, busy;
    logic [2*W-1:0] product, dp_product;
    logic [W-1:0]   dp_operand_a, dp_operand_b;
    logic           dp_select, dp_loadA, dp_loadB, dp_shift;

    multiply_arbiter #(.WIDTH(W)) dut (
        .clock(clock), .reset(reset), .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1),
        .product(product), .busy(busy),
        .dp_operand_a(dp_operand_a), .dp_operand_b(dp_operand_b),
        .dp_select(dp_select), .dp_loadA(dp_loadA), .dp_loadB(dp_loadB), .dp_shift(dp_shift),
        .dp_product(dp_product)
    );

    always #5 clock = ~clock;

    // Behavioural shift-add datapath driven by the strobes.
    logic [2*W:0] p_m = '0;
    logic [W-1:0] a_m = '0;
    always @(posedge clock) begin
        if (dp_loadA) a_m <= dp_operand_a;
        if (dp_loadB && !dp_select) p_m <= {{(W+1){1'b0}}, dp_operand_b};
        else if (dp_loadB && dp_select && p_m[0]) p_m[2*W:W] <= {1'b0, p_m[2*W-1:W]} + {1'b0, a_m};
        if (dp_shift) p_m <= p_m >> 1;
    end
    assign dp_product = p_m[2*W-1:0];

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct { int owner; int prod; } exp_t;
    exp_t sb[$];
    int   acks[$];

    // Reference model: an accepted operation occupies 19 non-IDLE cycles; done follows.
    int cyc_left = 0;
    int last_m   = 1;
    int own_m    = 0;
    bit fin_due  = 0;
    always @(negedge clock) begin
        if (reset) begin
            cyc_left = 0;
            last_m   = 1;
            fin_due  = 0;
            sb.delete();
        end else begin
            check("busy", busy, cyc_left != 0);
            check("ack0", ack0, cyc_left == 19 && own_m == 0);
            check("ack1", ack1, cyc_left == 19 && own_m == 1);
            check("done_timing", done0 | done1, fin_due);
            fin_due = 0;
            if (cyc_left == 0) begin
                if (req0 || req1) begin
                    own_m  = (req0 && req1) ? 1 - last_m : (req1 ? 1 : 0);
                    last_m = own_m;
                    sb.push_back('{own_m, own_m ? int'(a1) * int'(b1) : int'(a0) * int'(b0)});
                    cyc_left = 19;
                end
            end else begin
                cyc_left--;
                if (cyc_left == 0) fin_due = 1;
            end
        end
    end

    // Monitor: pops the scoreboard on each done and audits the strobe counts of that operation.
    exp_t e;
    int   held = 0;
    int   n_la = 0, n_lb = 0, n_lb0 = 0, n_sh = 0;
    always @(negedge clock) begin
        if (reset) begin
            held = 0;
            n_la = 0; n_lb = 0; n_lb0 = 0; n_sh = 0;
        end else begin
            if (done0 || done1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done0=%0d done1=%0d expected none", done0, done1);
                end else begin
                    e = sb.pop_front();
                    check("done_owner", done1, e.owner);
                    check("done_other", done0, 1 - e.owner);
                    check("product", product, e.prod);
                    check("loadA_count", n_la, 1);
                    check("loadB_count", n_lb, W + 1);
                    check("loadB_sel0_count", n_lb0, 1);
                    check("shift_count", n_sh, W);
                    held = e.prod;
                end
                n_la = 0; n_lb = 0; n_lb0 = 0; n_sh = 0;
            end else begin
                check("product_held", product, held);
            end
            if (ack0) acks.push_back(0);
            if (ack1) acks.push_back(1);
            n_la  += int'(dp_loadA);
            n_lb  += int'(dp_loadB);
            n_lb0 += int'(dp_loadB && !dp_select);
            n_sh  += int'(dp_shift);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_acks"}, {ack0, ack1}, 0);
        check({tag, "_dones"}, {done0, done1}, 0);
        check({tag, "_product"}, product, 0);
        check({tag, "_strobes"}, {dp_select, dp_loadA, dp_loadB, dp_shift}, 0);
        check({tag, "_operands"}, {dp_operand_a, dp_operand_b}, 0);
    endtask

    task automatic single(input int idx, input int a, input int b);
        if (idx == 0) begin req0 = 1; a0 = W'(a); b0 = W'(b); end
        else          begin req1 = 1; a1 = W'(a); b1 = W'(b); end
        step(1);
        req0 = 0; req1 = 0;
        a0 = W'($urandom); b0 = W'($urandom); a1 = W'($urandom); b1 = W'($urandom);
        step(22);
    endtask

    int exp_order[4] = '{0, 1, 0, 1};

    initial begin
        reset = 1; req0 = 0; req1 = 0; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        #1;
        check_zero("reset");
        step(2);
        reset = 0;

        single(0, 13, 11);
        check("single_13x11", product, 143);

        req0 = 1; a0 = 3; b0 = 5; req1 = 1; a1 = 7; b1 = 9;
        step(20);
        req0 = 0;
        step(1);
        req1 = 0;
        step(22);
        check("tie_second_7x9", product, 63);

        acks.delete();
        req0 = 1; req1 = 1;
        step(80);
        req0 = 0; req1 = 0;
        step(25);
        check("fair_count", acks.size(), 4);
        for (int i = 0; i < 4; i++)
            check("fair_order", (i < acks.size()) ? acks[i] : 9, exp_order[i]);

        single(0, 255, 255);
        check("ext_255x255", product, 65025);
        single(1, 0, 200);
        check("ext_0x200", product, 0);
        single(0, 1, 255);
        check("ext_1x255", product, 255);

        req0 = 1; a0 = 50; b0 = 60;
        step(1);
        req0 = 0;
        step(9);
        reset = 1;
        #1;
        check_zero("midreset");
        step(2);
        reset = 0;
        single(1, 2, 2);
        check("after_reset_2x2", product, 4);

        for (int c = 0; c < 600; c++) begin
            req0 = ($urandom_range(2) == 0);
            req1 = ($urandom_range(2) == 0);
            a0 = W'($urandom); b0 = W'($urandom);
            a1 = W'($urandom); b1 = W'($urandom);
            step(1);
        end
        req0 = 0; req1 = 0;
        step(25);
        check("drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
